dmem_arbiter: RTL and testbench

//   Shares the single-port data memory (dmem, 14-bit word address, 4-bit byte WE,
//   1-cycle synchronous read) between the CPU load/store port and a secondary bus

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arb_rsp.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : grant FSM state (ARB_IDLE, ARB_BURST)
//   owner_t     : requester identity used for grant history and read routing
//   DATA_W/WE_W : dmem data width and byte-enable width
package dmem_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   localparam int DATA_W = 32;
   localparam int WE_W   = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port dmem.
//   cpu_*   : CPU load/store request, grant and read-return signals
//   dma_*   : secondary master request (with burst lock), grant and read return
//   mem_*   : dmem port (enable, byte WE, word address, write data, read data)
// Modports:
//   master : requester/memory side (drives requests and mem_dout)
//   slave  : arbiter side (drives grants, read returns and the dmem port)
interface dmem_arbiter_if #(
   parameter int ADDR_W = 14
);
   import dmem_arb_pkg::*;

   logic              cpu_req;
   logic [WE_W-1:0]   cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_lock;
   logic [WE_W-1:0]   dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_en;
   logic [WE_W-1:0]   mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_din,
      output mem_dout
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_din,
      input  mem_dout
   );

endinterface

// File: rtl/dmem_arb_rsp.sv
// Read-return path of the dmem arbiter.
// A one-entry tag (valid + owner) records the read issued this cycle; next
// cycle the owner's rvalid pulses and its rdata shows mem_dout, after which
// a per-port hold register keeps the value until that port's next read.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   issue, issue_owner    : a read was granted this cycle, and to whom
//   mem_dout              : dmem read data (valid the cycle after issue)
//   cpu_rvalid/cpu_rdata  : CPU read return
//   dma_rvalid/dma_rdata  : DMA read return
module dmem_arb_rsp
   import dmem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  owner_t            issue_owner,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata
);

   logic                   tag_valid_reg;
   owner_t                 tag_owner_reg;
   logic [1:0]             rvalid;
   logic [1:0][DATA_W-1:0] rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_reg <= 1'b0;
         tag_owner_reg <= OWN_CPU;
      end else begin
         tag_valid_reg <= issue;
         tag_owner_reg <= issue_owner;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] hold_reg;

         // Gated by rst so a read caught in flight by reset never returns.
         assign rvalid[gi] = tag_valid_reg && !rst &&
                             (tag_owner_reg == ((gi == 0) ? OWN_CPU : OWN_DMA));

         always_ff @(posedge clk) begin
            if (rst) begin
               hold_reg <= '0;
            end else if (rvalid[gi]) begin
               hold_reg <= mem_dout;
            end
         end

         // Fresh data is visible in the rvalid cycle itself, then held.
         assign rdata[gi] = rvalid[gi] ? mem_dout : hold_reg;
      end
   endgenerate

   assign cpu_rvalid = rvalid[0];
   assign cpu_rdata  = rdata[0];
   assign dma_rvalid = rvalid[1];
   assign dma_rdata  = rdata[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU load/store port and a DMA/loader
// master. One requester is granted per cycle (combinational grant), the
// granted request drives the dmem port, and reads return to their issuer.
// A DMA beat with dma_lock opens a protected burst of up to MAX_BURST beats,
// after which the CPU is given one forced slot (yield).
// Optional feature macro: DMEM_ARB_FAIR_EN -- round-robin on idle contention;
// when undefined the CPU always wins idle contention.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_arbiter_if.slave (cpu_*, dma_*, mem_* signals)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int ADDR_W    = 14
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   localparam int                CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

   arb_state_t        state_reg;
   logic [CNT_W-1:0]  beat_cnt_reg;
   logic [CNT_W-1:0]  beat_cnt_next;
   logic              yield_reg;
   owner_t            last_gnt_reg;

   logic              cpu_gnt;
   logic              dma_gnt;
   logic [ADDR_W-1:0] addr_sel;
   logic              rd_issue;
   owner_t            rd_owner;

   // Grant selection. Reset suppresses both grants.
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!rst) begin
         if (state_reg == ARB_BURST && bus.dma_req) begin
            dma_gnt = 1'b1;
         end else if (bus.cpu_req && bus.dma_req) begin
            if (yield_reg) begin
               cpu_gnt = 1'b1;
`ifdef DMEM_ARB_FAIR_EN
            end else if (last_gnt_reg == OWN_CPU) begin
               dma_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
`else
            end else begin
               cpu_gnt = 1'b1;
            end
`endif
         end else begin
            cpu_gnt = bus.cpu_req;
            dma_gnt = bus.dma_req;
         end
      end
   end

`ifndef DMEM_ARB_FAIR_EN
   // Grant history is maintained but only consulted by the round-robin build.
   owner_t last_gnt_unused;
   assign last_gnt_unused = last_gnt_reg;
`endif

   assign bus.cpu_gnt = cpu_gnt;
   assign bus.dma_gnt = dma_gnt;

   // dmem port mux
   always_comb begin
      bus.mem_en  = cpu_gnt | dma_gnt;
      bus.mem_we  = '0;
      bus.mem_din = bus.cpu_wdata;
      addr_sel    = bus.cpu_addr;
      if (dma_gnt) begin
         bus.mem_we  = bus.dma_we;
         bus.mem_din = bus.dma_wdata;
         addr_sel    = bus.dma_addr;
      end else if (cpu_gnt) begin
         bus.mem_we  = bus.cpu_we;
      end
   end

   assign bus.mem_addr = addr_sel;

   // Saturating beat counter increment.
   assign beat_cnt_next = (beat_cnt_reg == MAX_CNT) ? beat_cnt_reg
                                                    : beat_cnt_reg + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ARB_IDLE;
         beat_cnt_reg <= '0;
         yield_reg    <= 1'b0;
         last_gnt_reg <= OWN_DMA;
      end else begin
         if (cpu_gnt) begin
            last_gnt_reg <= OWN_CPU;
         end else if (dma_gnt) begin
            last_gnt_reg <= OWN_DMA;
         end

         if (cpu_gnt) begin
            yield_reg <= 1'b0;
         end else if (state_reg == ARB_IDLE && !bus.cpu_req) begin
            yield_reg <= 1'b0;
         end

         case (state_reg)
            ARB_IDLE: begin
               if (dma_gnt && bus.dma_lock) begin
                  // With MAX_BURST=1 the opening beat already uses the whole
                  // allowance, so no protected state is entered.
                  if (MAX_BURST <= 1) begin
                     yield_reg <= 1'b1;
                  end else begin
                     state_reg    <= ARB_BURST;
                     beat_cnt_reg <= CNT_W'(1);
                  end
               end
            end
            ARB_BURST: begin
               if (!dma_gnt || !bus.dma_lock) begin
                  state_reg    <= ARB_IDLE;
                  beat_cnt_reg <= '0;
               end else if (beat_cnt_next >= MAX_CNT) begin
                  state_reg    <= ARB_IDLE;
                  beat_cnt_reg <= '0;
                  yield_reg    <= 1'b1;
               end else begin
                  beat_cnt_reg <= beat_cnt_next;
               end
            end
            default: begin
               state_reg    <= ARB_IDLE;
               beat_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign rd_issue = (cpu_gnt && bus.cpu_we == '0) || (dma_gnt && bus.dma_we == '0);
   assign rd_owner = dma_gnt ? OWN_DMA : OWN_CPU;

   dmem_arb_rsp u_rsp (
      .clk        (clk),
      .rst        (rst),
      .issue      (rd_issue),
      .issue_owner(rd_owner),
      .mem_dout   (bus.mem_dout),
      .cpu_rvalid (bus.cpu_rvalid),
      .cpu_rdata  (bus.cpu_rdata),
      .dma_rvalid (bus.dma_rvalid),
      .dma_rdata  (bus.dma_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference
// model (grant rules, lock-run counting, shadow memory, read scoreboard).
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int MAX_BURST = 8;
   localparam int ADDR_W    = 14;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Behavioural dmem: 1-cycle synchronous read, byte writes.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_din[8*b +: 8];
         bus.mem_dout <= mem[bus.mem_addr[5:0]];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [31:0] sh [0:63];
   int          run;          // consecutive locked DMA grants in the current run
   bit          m_yield;
   bit          m_last_dma;
   bit          pend_valid;
   bit          pend_dma;
   logic [31:0] pend_data;
   logic [31:0] held_c;
   logic [31:0] held_d;

   // Observations of the last step
   logic        obs_cg, obs_dg, obs_crv, obs_drv;
   logic [31:0] obs_cr, obs_dr;
   logic [3:0]  obs_we;

   task automatic model_reset();
      run        = 0;
      m_yield    = 1'b0;
      m_last_dma = 1'b1;
      pend_valid = 1'b0;
      pend_dma   = 1'b0;
      pend_data  = '0;
      held_c     = '0;
      held_d     = '0;
   endtask

   task automatic set_cpu(input bit req, input logic [3:0] we, input int addr, input logic [31:0] wd);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = ADDR_W'(addr);
      bus.cpu_wdata = wd;
   endtask

   task automatic set_dma(input bit req, input bit lock, input logic [3:0] we, input int addr,
                          input logic [31:0] wd);
      bus.dma_req   = req;
      bus.dma_lock  = lock;
      bus.dma_we    = we;
      bus.dma_addr  = ADDR_W'(addr);
      bus.dma_wdata = wd;
   endtask

   // One clock cycle: predict, check at negedge, advance model at posedge.
   task automatic step(output bit gc, output bit gd);
      bit              want_c, want_d, lock, ec, ed, rv_c, rv_d;
      logic [3:0]      c_we, d_we, ewe, w;
      logic [ADDR_W-1:0] c_addr, d_addr, a;
      logic [31:0]     c_wd, d_wd, wd, exp_cr, exp_dr;
      bit              in_rst;

      in_rst = rst;
      want_c = bus.cpu_req;  c_we = bus.cpu_we; c_addr = bus.cpu_addr; c_wd = bus.cpu_wdata;
      want_d = bus.dma_req;  d_we = bus.dma_we; d_addr = bus.dma_addr; d_wd = bus.dma_wdata;
      lock   = bus.dma_lock;

      ec = 1'b0;
      ed = 1'b0;
      if (!in_rst) begin
         if (want_d && !want_c) ed = 1'b1;
         else if (want_c && !want_d) ec = 1'b1;
         else if (want_c && want_d) begin
            if (run > 0) ed = 1'b1;          // protected beat of a locked run
            else if (m_yield) ec = 1'b1;     // CPU owed its slot after a full run
`ifdef DMEM_ARB_FAIR_EN
            else if (m_last_dma) ec = 1'b1;
            else ed = 1'b1;
`else
            else ec = 1'b1;
`endif
         end
      end
      ewe    = ed ? d_we : (ec ? c_we : 4'b0000);
      rv_c   = !in_rst && pend_valid && !pend_dma;
      rv_d   = !in_rst && pend_valid && pend_dma;
      exp_cr = rv_c ? pend_data : held_c;
      exp_dr = rv_d ? pend_data : held_d;

      @(negedge clk);
      obs_cg  = bus.cpu_gnt;   obs_dg = bus.dma_gnt;
      obs_crv = bus.cpu_rvalid; obs_drv = bus.dma_rvalid;
      obs_cr  = bus.cpu_rdata; obs_dr = bus.dma_rdata;
      obs_we  = bus.mem_we;
      chk("cpu_gnt",    32'(obs_cg), 32'(ec));
      chk("dma_gnt",    32'(obs_dg), 32'(ed));
      chk("both_gnt",   32'(obs_cg & obs_dg), 32'(0));
      chk("mem_en",     32'(bus.mem_en), 32'(ec | ed));
      chk("mem_we",     32'(obs_we), 32'(ewe));
      if (ec || ed) chk("mem_addr", 32'(bus.mem_addr), 32'(ed ? d_addr : c_addr));
      if ((ec || ed) && ewe != 4'b0000) chk("mem_din", bus.mem_din, ed ? d_wd : c_wd);
      chk("cpu_rvalid", 32'(obs_crv), 32'(rv_c));
      chk("dma_rvalid", 32'(obs_drv), 32'(rv_d));
      chk("cpu_rdata",  obs_cr, exp_cr);
      chk("dma_rdata",  obs_dr, exp_dr);

      if (ec) $display("%0t CPU %s addr=%h we=%b data=%h", $time, (c_we == 0) ? "RD" : "WR",
                       c_addr, c_we, (c_we == 0) ? sh[c_addr[5:0]] : c_wd);
      if (ed) $display("%0t DMA %s addr=%h we=%b lock=%0d data=%h", $time,
                       (d_we == 0) ? "RD" : "WR", d_addr, d_we, lock,
                       (d_we == 0) ? sh[d_addr[5:0]] : d_wd);

      @(posedge clk);
      if (in_rst) begin
         model_reset();
      end else begin
         if (rv_c) held_c = pend_data;
         if (rv_d) held_d = pend_data;
         pend_valid = 1'b0;
         if (ec || ed) begin
            a  = ed ? d_addr : c_addr;
            w  = ed ? d_we : c_we;
            wd = ed ? d_wd : c_wd;
            if (w == 4'b0000) begin
               pend_valid = 1'b1;
               pend_dma   = ed;
               pend_data  = sh[a[5:0]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (w[b]) sh[a[5:0]][8*b +: 8] = wd[8*b +: 8];
            end
            m_last_dma = ed;
         end
         if (ec) m_yield = 1'b0;
         else if (run == 0 && !want_c) m_yield = 1'b0;
         if (ed && lock) begin
            run++;
            if (run >= MAX_BURST) begin
               run     = 0;
               m_yield = 1'b1;
            end
         end else begin
            run = 0;
         end
      end
      gc = ec;
      gd = ed;
      #1;
   endtask

   task automatic do_reset();
      bit gc, gd;
      rst = 1'b1;
      step(gc, gd);
      rst = 1'b0;
   endtask

   initial begin
      bit gc, gd;
      int ncg, ndg, dma_left, dma_before_cpu, cpu_seen;

      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
         sh[i]  = mem[i];
      end
      mem[16] = 32'hDEADBEEF; sh[16] = 32'hDEADBEEF;
      mem[1]  = 32'h11111111; sh[1]  = 32'h11111111;
      mem[2]  = 32'h22222222; sh[2]  = 32'h22222222;
      mem[5]  = 32'h00000000; sh[5]  = 32'h00000000;

      rst = 1'b1;
      set_cpu(0, 4'b0000, 0, 0);
      set_dma(0, 0, 4'b0000, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // Reset state
      step(gc, gd);
      chk("rst_cpu_rdata", obs_cr, 32'h0);
      chk("rst_dma_rdata", obs_dr, 32'h0);

      // 1: lone CPU read
      set_cpu(1, 4'b0000, 16'h0010, 0);
      step(gc, gd);
      chk("t1_gnt", 32'(obs_cg), 32'(1));
      set_cpu(0, 4'b0000, 0, 0);
      step(gc, gd);
      chk("t1_rvalid", 32'(obs_crv), 32'(1));
      chk("t1_rdata", obs_cr, 32'hDEADBEEF);
      chk("t1_dma_rvalid", 32'(obs_drv), 32'(0));

      // 2: constant contention with single (unlocked) beats
      do_reset();
      set_cpu(1, 4'b0000, 3, 0);
      set_dma(1, 0, 4'b0000, 4, 0);
      ncg = 0;
      for (int k = 0; k < 6; k++) begin
         step(gc, gd);
         ncg += int'(obs_cg);
      end
`ifdef DMEM_ARB_FAIR_EN
      chk("t2_cpu_grants", 32'(ncg), 32'(3));
`else
      chk("t2_cpu_grants", 32'(ncg), 32'(6));
`endif
      set_cpu(0, 4'b0000, 0, 0);
      set_dma(0, 0, 4'b0000, 0, 0);
      step(gc, gd);

      // 3: 12-beat locked DMA burst against a waiting CPU
      do_reset();
      set_dma(1, 1, 4'b0000, 3, 0);
      dma_left = 12; dma_before_cpu = 0; cpu_seen = 0; ndg = 0;
      for (int k = 0; k < 30 && (dma_left > 0 || bus.cpu_req); k++) begin
         step(gc, gd);
         if (obs_dg) begin
            ndg++;
            if (cpu_seen == 0) dma_before_cpu++;
         end
         if (obs_cg) cpu_seen++;
         if (gd) begin
            dma_left--;
            if (dma_left == 0) set_dma(0, 0, 4'b0000, 0, 0);
         end
         if (gc) set_cpu(0, 4'b0000, 0, 0);
         else if (k == 0) set_cpu(1, 4'b0000, 4, 0);
      end
      chk("t3_dma_before_cpu", 32'(dma_before_cpu), 32'(MAX_BURST));
      chk("t3_cpu_grants", 32'(cpu_seen), 32'(1));
      chk("t3_dma_grants", 32'(ndg), 32'(12));
      step(gc, gd);

      // 4: alternating single-owner reads every cycle
      do_reset();
      ncg = 0; ndg = 0;
      for (int k = 0; k < 9; k++) begin
         if (k == 8) begin
            set_cpu(0, 4'b0000, 0, 0);
            set_dma(0, 0, 4'b0000, 0, 0);
         end else if (k % 2 == 0) begin
            set_cpu(1, 4'b0000, 1, 0);
            set_dma(0, 0, 4'b0000, 0, 0);
         end else begin
            set_cpu(0, 4'b0000, 0, 0);
            set_dma(1, 0, 4'b0000, 2, 0);
         end
         step(gc, gd);
         ncg += int'(obs_crv);
         ndg += int'(obs_drv);
      end
      chk("t4_cpu_rvalids", 32'(ncg), 32'(4));
      chk("t4_dma_rvalids", 32'(ndg), 32'(4));
      chk("t4_cpu_rdata", obs_cr, 32'h11111111);
      chk("t4_dma_rdata", obs_dr, 32'h22222222);

      // 5: partial DMA write, then CPU read-back
      set_dma(1, 0, 4'b0011, 5, 32'hAABBCCDD);
      step(gc, gd);
      chk("t5_mem_we", 32'(obs_we), 32'(4'b0011));
      set_dma(0, 0, 4'b0000, 0, 0);
      set_cpu(1, 4'b0000, 5, 0);
      step(gc, gd);
      chk("t5_no_dma_rvalid", 32'(obs_drv), 32'(0));
      set_cpu(0, 4'b0000, 0, 0);
      step(gc, gd);
      chk("t5_readback", obs_cr, 32'h0000CCDD);

      // 6: reset lands on an in-flight CPU read
      set_cpu(1, 4'b0000, 16'h0010, 0);
      step(gc, gd);
      set_cpu(0, 4'b0000, 0, 0);
      rst = 1'b1;
      step(gc, gd);
      chk("t6_rvalid_in_rst", 32'(obs_crv), 32'(0));
      rst = 1'b0;
      step(gc, gd);
      chk("t6_rvalid_after", 32'(obs_crv), 32'(0));
      chk("t6_rdata", obs_cr, 32'h0);

      // Random traffic
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 149) == 0);
         step(gc, gd);
         if (!bus.cpu_req || gc) begin
            set_cpu($urandom_range(0, 99) < 55,
                    ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                    int'($urandom_range(0, 31)), $urandom);
         end
         if (!bus.dma_req || gd) begin
            set_dma($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 70,
                    ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                    int'($urandom_range(0, 31)), $urandom);
         end
      end
      rst = 1'b0;
      set_cpu(0, 4'b0000, 0, 0);
      set_dma(0, 0, 4'b0000, 0, 0);
      step(gc, gd);
      step(gc, gd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
